// File: rtl/sa_pkg.sv
// Shared definitions for the swap controller: FSM encoding and statistics width.
package sa_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned STATS_W = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    DECIDE = 3'd2,
    WR_A   = 3'd3,
    WR_B   = 3'd4
  } state_e;

endpackage

// File: rtl/sa_sat_counter.sv
// Saturating up-counter, synchronous active-high clear.
module sa_sat_counter
  import sa_pkg::*;
#(
  parameter int unsigned W = STATS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Increment unless already at all-ones
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/sa_swap_ctrl.sv
// Read-decide-write swap controller in front of a 2R/1W cell memory.
// Optional accept/reject statistics are built when SA_SWAP_STATS_EN is defined.
module sa_swap_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DEPTH-1:0]   req_addr_a,
  input  logic [DEPTH-1:0]   req_addr_b,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data_a,
  output logic [WIDTH-1:0]   rd_data_b,
  input  logic               dec_valid,
  input  logic               dec_accept,
  output logic               done,
  output logic [DEPTH-1:0]   mem_rd_addr0,
  output logic [DEPTH-1:0]   mem_rd_addr1,
  input  logic [WIDTH-1:0]   mem_rd_data0,
  input  logic [WIDTH-1:0]   mem_rd_data1,
  output logic               mem_wr,
  output logic [DEPTH-1:0]   mem_wr_addr,
  output logic [WIDTH-1:0]   mem_wr_data,
  output logic [STATS_W-1:0] accept_cnt,
  output logic [STATS_W-1:0] reject_cnt
);

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [WIDTH-1:0]   data_a_q, data_a_d, data_b_q, data_b_d;
  logic               req_ready_q, req_ready_d;
  logic               rd_valid_q, rd_valid_d;
  logic               done_q, done_d;
  logic               mem_wr_q, mem_wr_d;
  logic [DEPTH-1:0]   mem_wr_addr_q, mem_wr_addr_d;
  logic [WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;

  // Next state, operand capture, and registered outputs derived from next state
  always_comb begin
    state_d       = state_q;
    addr_a_d      = addr_a_q;
    addr_b_d      = addr_b_q;
    data_a_d      = data_a_q;
    data_b_d      = data_b_q;
    done_d        = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_a_d = req_addr_a;
          addr_b_d = req_addr_b;
          state_d  = READ;
        end
      end
      READ: begin
        data_a_d = mem_rd_data0;
        data_b_d = mem_rd_data1;
        state_d  = DECIDE;
      end
      DECIDE: begin
        if (dec_valid) begin
          // Same-address accept is a no-op swap: finish like a reject
          if (dec_accept && (addr_a_q != addr_b_q)) begin
            state_d = WR_A;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      WR_A: state_d = WR_B;
      WR_B: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    rd_valid_d  = (state_d == DECIDE);
    mem_wr_d    = (state_d == WR_A) || (state_d == WR_B);
    if (state_d == WR_A) begin
      mem_wr_addr_d = addr_a_d;
      mem_wr_data_d = data_b_d;
    end else if (state_d == WR_B) begin
      mem_wr_addr_d = addr_b_d;
      mem_wr_data_d = data_a_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_a_q      <= '0;
      addr_b_q      <= '0;
      data_a_q      <= '0;
      data_b_q      <= '0;
      req_ready_q   <= 1'b1;
      rd_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_a_q      <= addr_a_d;
      addr_b_q      <= addr_b_d;
      data_a_q      <= data_a_d;
      data_b_q      <= data_b_d;
      req_ready_q   <= req_ready_d;
      rd_valid_q    <= rd_valid_d;
      done_q        <= done_d;
      mem_wr_q      <= mem_wr_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data_a    = data_a_q;
  assign rd_data_b    = data_b_q;
  assign done         = done_q;
  assign mem_rd_addr0 = addr_a_q;
  assign mem_rd_addr1 = addr_b_q;
  assign mem_wr       = mem_wr_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;

`ifdef SA_SWAP_STATS_EN
  logic accept_inc_c, reject_inc_c;

  // Count every DECIDE exit by decision outcome
  always_comb begin
    accept_inc_c = (state_q == DECIDE) && dec_valid && dec_accept;
    reject_inc_c = (state_q == DECIDE) && dec_valid && !dec_accept;
  end

  sa_sat_counter #(.W(STATS_W)) u_accept_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept_inc_c),
    .count (accept_cnt)
  );

  sa_sat_counter #(.W(STATS_W)) u_reject_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (reject_inc_c),
    .count (reject_cnt)
  );
`else
  assign accept_cnt = '0;
  assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_swap_ctrl.sv
// Self-checking bench for sa_swap_ctrl with an attached behavioural 2R/1W memory.
module tb_sa_swap_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NCELL = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [DEPTH-1:0] req_addr_a, req_addr_b;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data_a, rd_data_b;
  logic             dec_valid, dec_accept;
  logic             done;
  logic [DEPTH-1:0] mem_rd_addr0, mem_rd_addr1;
  logic [WIDTH-1:0] mem_rd_data0, mem_rd_data1;
  logic             mem_wr;
  logic [DEPTH-1:0] mem_wr_addr;
  logic [WIDTH-1:0] mem_wr_data;
  logic [15:0]      accept_cnt, reject_cnt;

  sa_swap_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr_a   (req_addr_a),
    .req_addr_b   (req_addr_b),
    .rd_valid     (rd_valid),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .dec_valid    (dec_valid),
    .dec_accept   (dec_accept),
    .done         (done),
    .mem_rd_addr0 (mem_rd_addr0),
    .mem_rd_addr1 (mem_rd_addr1),
    .mem_rd_data0 (mem_rd_data0),
    .mem_rd_data1 (mem_rd_data1),
    .mem_wr       (mem_wr),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .accept_cnt   (accept_cnt),
    .reject_cnt   (reject_cnt)
  );

  always #5 clk = ~clk;

  // Cell memory: async reads, write at clock edge, bulk preload cell i = i+0x10
  logic [WIDTH-1:0] mem [NCELL];
  logic             mem_init;
  assign mem_rd_data0 = mem[mem_rd_addr0];
  assign mem_rd_data1 = mem[mem_rd_addr1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < NCELL; i++) mem[i] <= WIDTH'(i + 16);
    end else if (mem_wr) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  // Reference model: expected memory contents and decision tallies
  int ref_mem [NCELL];
  int acc_ref, rej_ref;
  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < NCELL; i++) check("mem_cell", 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  task automatic check_cnt();
`ifdef SA_SWAP_STATS_EN
    check("accept_cnt", 32'(accept_cnt), 32'(acc_ref));
    check("reject_cnt", 32'(reject_cnt), 32'(rej_ref));
`else
    check("accept_cnt", 32'(accept_cnt), 32'd0);
    check("reject_cnt", 32'(reject_cnt), 32'd0);
`endif
  endtask

  // One full transaction; returns in the done cycle so another may start at once
  task automatic swap_txn(input int a, input int b, input bit acc, input int hold);
    int da, db, tmp;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_addr_a = DEPTH'(a);
    req_addr_b = DEPTH'(b);
    step();
    req_valid  = 1'b0;
    req_addr_a = DEPTH'($urandom);
    req_addr_b = DEPTH'($urandom);
    // READ cycle: a stray decision here must be ignored
    check("read_rd_valid", 32'(rd_valid), 32'd0);
    check("read_ready", 32'(req_ready), 32'd0);
    check("read_addr0", 32'(mem_rd_addr0), 32'(a));
    check("read_addr1", 32'(mem_rd_addr1), 32'(b));
    dec_valid  = 1'b1;
    dec_accept = 1'b0;
    step();
    dec_valid  = 1'b0;
    da = ref_mem[a];
    db = ref_mem[b];
    for (int k = 0; k <= hold; k++) begin
      check("dec_rd_valid", 32'(rd_valid), 32'd1);
      check("dec_rd_data_a", 32'(rd_data_a), 32'(da));
      check("dec_rd_data_b", 32'(rd_data_b), 32'(db));
      check("dec_no_wr", 32'(mem_wr), 32'd0);
      check("dec_not_ready", 32'(req_ready), 32'd0);
      if (k < hold) begin
        req_valid  = 1'b1;
        dec_accept = 1'($urandom);
        step();
        req_valid  = 1'b0;
      end
    end
    dec_valid  = 1'b1;
    dec_accept = acc;
    step();
    dec_valid  = 1'b0;
    dec_accept = 1'b0;
    if (acc) acc_ref++;
    else     rej_ref++;
    if (acc && (a != b)) begin
      check("wra_wr", 32'(mem_wr), 32'd1);
      check("wra_addr", 32'(mem_wr_addr), 32'(a));
      check("wra_data", 32'(mem_wr_data), 32'(db));
      check("wra_done", 32'(done), 32'd0);
      step();
      check("wrb_wr", 32'(mem_wr), 32'd1);
      check("wrb_addr", 32'(mem_wr_addr), 32'(b));
      check("wrb_data", 32'(mem_wr_data), 32'(da));
      step();
      tmp = ref_mem[a];
      ref_mem[a] = ref_mem[b];
      ref_mem[b] = tmp;
    end
    check("end_done", 32'(done), 32'd1);
    check("end_ready", 32'(req_ready), 32'd1);
    check("end_no_wr", 32'(mem_wr), 32'd0);
    check("end_rd_valid", 32'(rd_valid), 32'd0);
    check_mem();
    check_cnt();
  endtask

  initial begin
    int a, b;
    rst        = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_addr_a = '0;
    req_addr_b = '0;
    dec_valid  = 1'b0;
    dec_accept = 1'b0;
    for (int i = 0; i < NCELL; i++) ref_mem[i] = i + 16;
    acc_ref = 0;
    rej_ref = 0;
    step();
    step();
    mem_init = 1'b0;
    rst      = 1'b0;

    // Reset state
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr", 32'(mem_wr), 32'd0);
    check("rst_rd_data_a", 32'(rd_data_a), 32'd0);
    check("rst_rd_addr0", 32'(mem_rd_addr0), 32'd0);
    check("rst_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("rst_wr_data", 32'(mem_wr_data), 32'd0);
    check_cnt();

    // Basic accept, then done must drop
    swap_txn(2, 5, 1'b1, 0);
    check("swap_cell2", 32'(mem[2]), 32'h15);
    check("swap_cell5", 32'(mem[5]), 32'h12);
    step();
    check("done_pulse_len", 32'(done), 32'd0);

    // Reject and same-address accept
    swap_txn(3, 7, 1'b0, 0);
    swap_txn(4, 4, 1'b1, 0);
    check("same_cell4", 32'(mem[4]), 32'h14);

    // Back-to-back swap and restore, second request issued in the done cycle
    swap_txn(1, 2, 1'b1, 0);
    swap_txn(1, 2, 1'b1, 0);
    check("restore_cell1", 32'(mem[1]), 32'h11);

    // Long decision wait
    step();
    swap_txn(10, 11, 1'b1, 10);

    // Reset during WR_A leaves a half-written swap
    step();
    req_valid  = 1'b1;
    req_addr_a = DEPTH'(6);
    req_addr_b = DEPTH'(9);
    step();
    req_valid = 1'b0;
    step();
    dec_valid  = 1'b1;
    dec_accept = 1'b1;
    step();
    dec_valid = 1'b0;
    check("rstwr_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ref_mem[6] = ref_mem[9];
    acc_ref = 0;
    rej_ref = 0;
    check("rstwr_wr_off", 32'(mem_wr), 32'd0);
    check("rstwr_ready", 32'(req_ready), 32'd1);
    check("rstwr_done", 32'(done), 32'd0);
    check("rstwr_rd_valid", 32'(rd_valid), 32'd0);
    check("rstwr_addr0", 32'(mem_rd_addr0), 32'd0);
    check_mem();
    check_cnt();

    // Randomized transactions against the reference model
    for (int n = 0; n < 30; n++) begin
      a = int'($urandom_range(0, NCELL - 1));
      b = ($urandom_range(0, 4) == 0) ? a : int'($urandom_range(0, NCELL - 1));
      swap_txn(a, b, 1'($urandom), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        step();
        check("gap_done", 32'(done), 32'd0);
        check("gap_ready", 32'(req_ready), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_swap_ctrl.md
# sa_swap_ctrl

Read-decide-write controller that sits directly upstream of the 2-read/1-write cell memory used by the annealing engine. Given two cell addresses, it reads both cells in one cycle through the two asynchronous read ports and presents the values to the cost/decision logic. It then either writes the two values back exchanged through the single write port over two cycles, or discards them. It owns the memory's address and write-port signals exclusively.

## Interface
Parameters:
- WIDTH, 8, cell data width in bits
- DEPTH, 4, address width in bits (memory holds 2**DEPTH cells)

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- req_valid  in  1  swap request present
- req_ready  out  1  controller idle; request accepted when req_valid & req_ready
- req_addr_a  in  DEPTH  first cell address
- req_addr_b  in  DEPTH  second cell address
- rd_valid  out  1  rd_data_a/rd_data_b hold captured cell values; decision awaited
- rd_data_a  out  WIDTH  value of cell addr_a
- rd_data_b  out  WIDTH  value of cell addr_b
- dec_valid  in  1  decision present; sampled only while rd_valid
- dec_accept  in  1  1 = perform swap, 0 = discard
- done  out  1  one-cycle pulse, transaction finished
- mem_rd_addr0  out  DEPTH  to memory read port 0
- mem_rd_addr1  out  DEPTH  to memory read port 1
- mem_rd_data0  in  WIDTH  memory read port 0 data, combinational from mem_rd_addr0
- mem_rd_data1  in  WIDTH  memory read port 1 data, combinational from mem_rd_addr1
- mem_wr  out  1  memory write enable
- mem_wr_addr  out  DEPTH  memory write address
- mem_wr_data  out  WIDTH  memory write data
- accept_cnt  out  16  accepted swaps, with SA_SWAP_STATS_EN
- reject_cnt  out  16  rejected swaps, with SA_SWAP_STATS_EN

## Operation
- FSM states: IDLE, READ, DECIDE, WR_A, WR_B.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr_a and req_addr_b into addr_a and addr_b, then go to READ.
- READ, one cycle:
  - mem_rd_addr0=addr_a, mem_rd_addr1=addr_b.
  - Capture mem_rd_data0 into data_a and mem_rd_data1 into data_b at the clock edge, then go to DECIDE.
- DECIDE:
  - rd_valid=1; rd_data_a=data_a, rd_data_b=data_b.
  - Hold until dec_valid=1.
  - If dec_accept=1 and addr_a!=addr_b, go to WR_A.
  - Otherwise, covering reject and the same-address case, go to IDLE with no write.
- WR_A: mem_wr=1, mem_wr_addr=addr_a, mem_wr_data=data_b; next state WR_B.
- WR_B: mem_wr=1, mem_wr_addr=addr_b, mem_wr_data=data_a; next state IDLE.
- done is registered. It is high for the first IDLE cycle after DECIDE-reject or after WR_B.
- Same-address accept:
  - Counted as accepted.
  - No write is issued.
  - done follows as for reject.
- mem_wr=0 in every state other than WR_A/WR_B.
- mem_rd_addr0/1 hold addr_a/addr_b in all states. Outputs are never X.
- Request inputs are ignored outside IDLE.
- dec_valid outside DECIDE is ignored.

## Timing
- Reset values:
  - state=IDLE; req_ready=1.
  - rd_valid=0, done=0, mem_wr=0.
  - addr_a, addr_b, data_a, data_b, rd_data_*, mem_* addresses and data all 0.
  - Counters 0.
- Request accepted at edge t:
  - READ in cycle t+1.
  - rd_valid from cycle t+2.
- Decision sampled at edge d, accept:
  - WR_A in cycle d+1, WR_B in d+2.
  - done and req_ready in d+3.
- Decision sampled at edge d, reject: done and req_ready in d+1.
- A new request may be accepted in the same cycle done is high.
- Minimum accept transaction: 5 cycles request-to-request with an immediate decision.
- Minimum reject transaction: 3 cycles request-to-request with an immediate decision.
- Memory write takes effect at the end of the WR cycle. A READ following immediately sees the new values.
- rst mid-operation:
  - Abort to IDLE next edge; mem_wr=0.
  - A swap interrupted after WR_A is left half-written. Recovery is not this block's responsibility.
  - No done pulse.

## Configuration
- SA_SWAP_STATS_EN defined:
  - accept_cnt increments on each DECIDE exit with dec_accept=1.
  - reject_cnt increments on each DECIDE exit with dec_accept=0.
  - Both are 16-bit, saturate at 0xFFFF, and are cleared by rst.
- SA_SWAP_STATS_EN undefined: accept_cnt and reject_cnt are tied to 0 and no counter logic is generated.

## Structure
- Shared package sa_pkg holds:
  - FSM state encoding localparams: IDLE=0, READ=1, DECIDE=2, WR_A=3, WR_B=4, 3 bits.
  - STATS_W=16.
- Sub-module sa_sat_counter holds the saturating counter and is instantiated twice under SA_SWAP_STATS_EN.
- The memory itself is a sibling instance wired at the parent level, not inside this block.

## Test plan
- Memory preloaded so cell i = i+0x10. Request a=2, b=5, accept immediately:
  - rd_data_a=0x12, rd_data_b=0x15.
  - Then mem[2]=0x15, mem[5]=0x12.
  - done at d+3.
- Same preload, request a=3, b=7, reject:
  - mem_wr never asserted; mem unchanged.
  - done at d+1.
  - reject_cnt=1 with SA_SWAP_STATS_EN.
- Request a=b=4, accept: no write, mem[4] unchanged, done at d+1, accept_cnt=1.
- Back-to-back:
  - Swap (1,2) accept, then a request (1,2) issued in the done cycle.
  - The second read returns the swapped values.
  - A second accept restores the original contents.
- Hold dec_valid=0 for 10 cycles in DECIDE:
  - rd_valid stays 1, data stable, no write.
  - Then accept: writes in next two cycles.
- Assert rst during WR_A:
  - Next cycle state=IDLE, mem_wr=0, req_ready=1, done=0.
  - mem[addr_a] written, mem[addr_b] unchanged.
